pipe_stage_reg: RTL and testbench

Generic, parametrised inter-stage pipeline register for the P7 exception-capable MIPS pipeline. It replaces the per-boundary hand-written F/D, D/E, E/M and M/W registers. It carries the instruction, PC, delay-slot flag, exception code and a generic sidecar payload. Controls are stall, flush and bubble insertion, and the block merges exceptions so the earliest one wins. It also keeps a saturating stall-duration counter for hazard debugging.

---
 rtl/cpu_pipe_pkg.sv | 34 +++
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 91 +++++++++
 tb/tb_pipe_stage_reg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared constants and types for the inter-stage pipeline registers of the
// exception-capable pipeline.
package cpu_pipe_pkg;

  localparam logic [4:0]  EXC_NONE         = 5'd0;
  localparam logic [31:0] NOP_INSTR        = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3004;
  localparam logic [31:0] DEFAULT_FLUSH_PC = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exccode_e;

  // Fixed-width slot contents; the sidecar payload is kept separately because
  // its width is a per-boundary parameter.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        delay_slot;
    logic [4:0]  exccode;
  } slot_t;

  // The older (upstream) exception takes precedence over one raised here.
  function automatic logic [4:0] merge_exccode(input logic [4:0] upstream,
                                               input logic [4:0] local_exc);
    return (upstream != EXC_NONE) ? upstream : local_exc;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with flush/stall/bubble control,
// exception merging and a stall-duration counter.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] FLUSH_PC = DEFAULT_FLUSH_PC,
  parameter int          CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic              in_delay_slot,
  input  logic [4:0]        in_exccode,
  input  logic [4:0]        stage_exccode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              out_delay_slot,
  output logic [4:0]        out_exccode,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam slot_t RESET_SLOT = '{valid: 1'b0, instr: NOP_INSTR, pc: RESET_PC,
                                   delay_slot: 1'b0, exccode: EXC_NONE};
  localparam slot_t FLUSH_SLOT = '{valid: 1'b0, instr: NOP_INSTR, pc: FLUSH_PC,
                                   delay_slot: 1'b0, exccode: EXC_NONE};

  slot_t             slot_reg;
  slot_t             slot_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;
  logic              live;

  // A slot is "live" only when a real instruction is loaded; bubbles and
  // invalid slots keep PC/BD so EPC can still be formed from them.
  assign live = in_valid && !bubble;

  always_comb begin
    slot_next = slot_reg;
    data_next = data_reg;
    if (flush) begin
      slot_next = FLUSH_SLOT;
      data_next = '0;
    end else if (!stall) begin
      slot_next.valid      = live;
      slot_next.instr      = live ? in_instr : NOP_INSTR;
      slot_next.pc         = in_pc;
      slot_next.delay_slot = in_delay_slot;
      slot_next.exccode    = live ? merge_exccode(in_exccode, stage_exccode) : EXC_NONE;
      data_next            = live ? in_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg <= RESET_SLOT;
      data_reg <= '0;
    end else begin
      slot_reg <= slot_next;
      data_reg <= data_next;
    end
  end

  // Flush kills a stalled register, so it also ends the stall run.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall),
    .clr  (flush || !stall),
    .count(stall_cnt)
  );

  assign out_valid      = slot_reg.valid;
  assign out_instr      = slot_reg.instr;
  assign out_pc         = slot_reg.pc;
  assign out_delay_slot = slot_reg.delay_slot;
  assign out_exccode    = slot_reg.exccode;
  assign out_data       = data_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then randomized cycles, all
// checked against a priority-rule model of the register.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset, stall, flush, bubble;
  logic        in_valid, in_delay_slot;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  in_exccode, stage_exccode;
  logic [63:0] in_data;

  logic        out_valid, out_delay_slot;
  logic [31:0] out_instr, out_pc;
  logic [4:0]  out_exccode;
  logic [63:0] out_data;
  logic [7:0]  stall_cnt;

  logic        s2_valid, s2_delay_slot;
  logic [31:0] s2_instr, s2_pc;
  logic [4:0]  s2_exccode;
  logic [63:0] s2_data;
  logic [1:0]  s2_cnt;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_delay_slot(in_delay_slot), .in_exccode(in_exccode),
    .stage_exccode(stage_exccode), .in_data(in_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_delay_slot(out_delay_slot), .out_exccode(out_exccode),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_delay_slot(in_delay_slot), .in_exccode(in_exccode),
    .stage_exccode(stage_exccode), .in_data(in_data),
    .out_valid(s2_valid), .out_instr(s2_instr), .out_pc(s2_pc),
    .out_delay_slot(s2_delay_slot), .out_exccode(s2_exccode),
    .out_data(s2_data), .stall_cnt(s2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model state
  bit          m_valid, m_ds;
  bit [31:0]   m_instr, m_pc;
  bit [4:0]    m_exc;
  bit [63:0]   m_data;
  int          m_cnt8, m_cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      {m_valid, m_ds, m_instr, m_exc, m_data} = '0;
      m_pc = 32'h0000_3004;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (flush) begin
      {m_valid, m_ds, m_instr, m_exc, m_data} = '0;
      m_pc = 32'h0000_4180;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (stall) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end else begin
      m_cnt8 = 0;
      m_cnt2 = 0;
      m_pc = in_pc;
      m_ds = in_delay_slot;
      if (bubble || !in_valid) begin
        m_valid = 0; m_instr = 0; m_exc = 0; m_data = 0;
      end else begin
        m_valid = 1;
        m_instr = in_instr;
        m_data  = in_data;
        m_exc   = (in_exccode != 0) ? in_exccode : stage_exccode;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  64'(out_valid),      64'(m_valid));
    chk({tag, ".instr"},  64'(out_instr),      64'(m_instr));
    chk({tag, ".pc"},     64'(out_pc),         64'(m_pc));
    chk({tag, ".ds"},     64'(out_delay_slot), 64'(m_ds));
    chk({tag, ".exc"},    64'(out_exccode),    64'(m_exc));
    chk({tag, ".data"},   out_data,            m_data);
    chk({tag, ".cnt"},    64'(stall_cnt),      64'(m_cnt8));
    chk({tag, ".cnt2"},   64'(s2_cnt),         64'(m_cnt2));
    chk({tag, ".pc2"},    64'(s2_pc),          64'(m_pc));
    $display("step %-10s st=%0b fl=%0b bu=%0b rs=%0b v=%0b pc=%h exc=%0d cnt=%0d cnt2=%0d",
             tag, stall, flush, bubble, reset, out_valid, out_pc, out_exccode, stall_cnt, s2_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ds, input logic [4:0] ie, input logic [4:0] se);
    in_valid = v; in_instr = ins; in_pc = pc; in_delay_slot = ds;
    in_exccode = ie; stage_exccode = se; in_data = {ins, pc};
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; bubble = 0;
    set_in(0, 32'h0, 32'h0, 0, 0, 0);
    step("reset");
    chk("reset_pc_lit", 64'(out_pc), 64'h3004);
    reset = 0;

    // Plain load
    set_in(1, 32'h2408_0005, 32'h3000, 0, 0, 0);
    step("load");
    chk("load_instr_lit", 64'(out_instr), 64'h2408_0005);
    chk("load_pc_lit", 64'(out_pc), 64'h3000);

    // Stall three cycles while inputs change
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h1000 + 32'(i), 32'h3100 + 32'(4 * i), 1, 5'd12, 5'd5);
      step("stall");
      chk("stall_cnt_lit", 64'(stall_cnt), 64'(i + 1));
    end
    chk("stall_hold_lit", 64'(out_instr), 64'h2408_0005);
    stall = 0;
    set_in(1, 32'h8c09_0000, 32'h3004, 0, 0, 0);
    step("unstall");
    chk("unstall_cnt_lit", 64'(stall_cnt), 64'd0);

    // Five stalls: 2-bit counter sticks at 3
    stall = 1;
    for (int i = 0; i < 5; i++) step("stall5");
    chk("sat2_lit", 64'(s2_cnt), 64'd3);
    chk("cnt8_5_lit", 64'(stall_cnt), 64'd5);

    // Flush together with stall at stall_cnt=5
    flush = 1;
    step("flushstl");
    chk("flush_pc_lit", 64'(out_pc), 64'h4180);
    flush = 0; stall = 0;

    // Bubble keeps PC/BD
    bubble = 1;
    set_in(1, 32'h0000_000C, 32'h3010, 1, 0, 0);
    step("bubble");
    chk("bubble_pc_lit", 64'(out_pc), 64'h3010);
    chk("bubble_ds_lit", 64'(out_delay_slot), 64'd1);
    bubble = 0;

    // Exception merge
    set_in(1, 32'h1234_5678, 32'h3020, 0, 5'd4, 5'd10);
    step("exc_up");
    chk("exc_up_lit", 64'(out_exccode), 64'd4);
    set_in(1, 32'h1234_5678, 32'h3024, 0, 5'd0, 5'd10);
    step("exc_loc");
    chk("exc_loc_lit", 64'(out_exccode), 64'd10);
    set_in(0, 32'h1234_5678, 32'h3028, 1, 5'd0, 5'd10);
    step("exc_inv");
    chk("exc_inv_lit", 64'(out_exccode), 64'd0);
    set_in(1, 32'h0, 32'h302c, 0, 5'd31, 5'd0);
    step("exc_odd");

    // Reset in the middle of a stall
    set_in(1, 32'hdead_beef, 32'h3abc, 0, 0, 0);
    step("load3abc");
    stall = 1;
    step("stallA");
    step("stallB");
    reset = 1;
    step("rst_mid");
    chk("rst_mid_pc_lit", 64'(out_pc), 64'h3004);
    chk("rst_mid_cnt_lit", 64'(stall_cnt), 64'd0);
    reset = 0; stall = 0;
    set_in(1, 32'h2408_0005, 32'h3000, 0, 0, 0);
    step("post_rst");

    // Randomized cycles
    for (int i = 0; i < 300; i++) begin
      reset  = ($urandom_range(0, 99) < 2);
      flush  = ($urandom_range(0, 99) < 6);
      stall  = ($urandom_range(0, 99) < 35);
      bubble = ($urandom_range(0, 99) < 15);
      in_valid      = ($urandom_range(0, 99) < 80);
      in_instr      = $urandom;
      in_pc         = $urandom;
      in_delay_slot = 1'($urandom_range(0, 1));
      in_exccode    = ($urandom_range(0, 99) < 50) ? 5'd0 : 5'($urandom_range(0, 31));
      stage_exccode = ($urandom_range(0, 99) < 50) ? 5'd0 : 5'($urandom_range(0, 31));
      in_data       = {$urandom, $urandom};
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
